// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, issues one instruction fetch at a
// time and holds the returned word in a one-entry IF output register for decode.
// EX redirects retarget the PC and flush the IF register. A kill flag marks an
// in-flight fetch made stale by a redirect so that its response is discarded.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redir_valid,
  input  logic [2:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_imm,
  input  logic [31:0] redir_aluout,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_JALR   = 3'd3;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        ifValid_q, ifValid_d;
  logic [31:0] ifPc_q, ifPc_d;
  logic [31:0] ifInstr_q, ifInstr_d;

  logic [31:0] redirTarget;
  logic        redirAct;
  logic        reqHandshake;

  // A request may only go out when the IF register will be free by the time the response lands.
  assign imem_req_valid = (state_q == ST_FETCH) && (!ifValid_q || if_ready);
  assign imem_req_addr  = pc_q;
  assign reqHandshake   = imem_req_valid && imem_req_ready;
  assign redirAct       = redir_valid && (state_q != ST_BOOT);

  assign if_valid = ifValid_q;
  assign if_pc    = ifPc_q;
  assign if_instr = ifInstr_q;

  // Redirect target selection; unknown opcodes fall back to the sequential PC.
  always_comb begin
    redirTarget = redir_pc + 32'd4;
    case (redir_op)
      OP_BRANCH, OP_JUMP: redirTarget = redir_pc + redir_imm;
      OP_JALR:            redirTarget = redir_aluout & 32'hFFFF_FFFE;
      default:            redirTarget = redir_pc + 32'd4;
    endcase
  end

  // Next-state logic: fetch handshake, response capture, consumption and redirect override.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    ifValid_d = ifValid_q;
    ifPc_d    = ifPc_q;
    ifInstr_d = ifInstr_q;

    if (ifValid_q && if_ready) begin
      ifValid_d = 1'b0;
    end

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (reqHandshake) begin
          state_d = ST_WAIT;
          if (redirAct) begin
            kill_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = ST_FETCH;
          kill_d  = 1'b0;
          if (!kill_q && !redirAct) begin
            ifValid_d = 1'b1;
            ifPc_d    = pc_q;
            ifInstr_d = imem_rsp_data;
            pc_d      = pc_q + 32'd4;
          end
        end else if (redirAct) begin
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (redirAct) begin
      pc_d      = redirTarget;
      ifValid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      ifValid_q <= 1'b0;
      ifPc_q    <= 32'd0;
      ifInstr_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      ifValid_q <= ifValid_d;
      ifPc_q    <= ifPc_d;
      ifInstr_q <= ifInstr_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed steps, a bench-side instruction memory with
// configurable latency, and a scoreboard of expected {pc, instr} pairs.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redir_valid;
  logic [2:0]  redir_op;
  logic [31:0] redir_pc;
  logic [31:0] redir_imm;
  logic [31:0] redir_aluout;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  int          checks = 0;
  int          errors = 0;
  int          loads  = 0;

  logic [63:0] expQ[$];
  logic [31:0] expPc;
  logic [31:0] redirExpTarget;
  logic        bootFlag;
  logic        memActive;
  int          memWait;
  int          memLatency;
  logic [31:0] memAddr;
  logic [31:0] heldPc;
  logic [31:0] heldInstr;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redir_valid    (redir_valid),
    .redir_op       (redir_op),
    .redir_pc       (redir_pc),
    .redir_imm      (redir_imm),
    .redir_aluout   (redir_aluout),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a << 8) ^ 32'h1300_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: record the handshake, update the scoreboard, model the memory,
  // then check the IF register after the edge.
  task automatic applyStimulus();
    logic        hs;
    logic        rspNow;
    logic        redirNow;
    logic        rstNow;
    logic        inBoot;
    logic [31:0] hsAddr;
    logic [63:0] e;
    #1;
    rstNow   = !rstn;
    inBoot   = bootFlag;
    hs       = imem_req_valid && imem_req_ready && !rstNow;
    hsAddr   = imem_req_addr;
    rspNow   = imem_rsp_valid && !rstNow;
    redirNow = redir_valid && !rstNow && !inBoot;
    if (hs) begin
      checkOutput("req_addr", hsAddr, expPc);
      if (!redirNow) begin
        expQ.push_back({expPc, memData(expPc)});
        expPc = expPc + 32'd4;
      end
    end
    if (redirNow) begin
      expQ.delete();
      expPc = redirExpTarget;
    end
    @(posedge clk);
    bootFlag = rstNow;
    if (rstNow) begin
      expQ.delete();
      expPc = RESET_PC;
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (rstNow) begin
      memActive = 1'b0;
    end else if (hs) begin
      memActive = 1'b1;
      memWait   = memLatency - 1;
      memAddr   = hsAddr;
    end else if (memActive && memWait > 0) begin
      memWait--;
    end
    if (memActive && memWait == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memData(memAddr);
      memActive      = 1'b0;
    end
    if (redirNow) begin
      checkOutput("flush_if_valid", 32'(if_valid), 32'd0);
    end else if (rspNow) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("load_if_valid", 32'(if_valid), 32'd1);
        checkOutput("load_if_pc", if_pc, e[63:32]);
        checkOutput("load_if_instr", if_instr, e[31:0]);
        heldPc    = e[63:32];
        heldInstr = e[31:0];
        loads++;
      end else begin
        checkOutput("stale_drop", 32'(if_valid), 32'd0);
      end
    end
  endtask

  task automatic waitLoads(input int n, input int budget);
    int target;
    int c;
    target = loads + n;
    c = 0;
    while (loads < target && c < budget) begin
      applyStimulus();
      c++;
    end
    if (loads < target) checkOutput("load_timeout", 32'(loads), 32'(target));
  endtask

  task automatic waitReq(input int budget);
    int c;
    c = 0;
    while (imem_req_valid !== 1'b1 && c < budget) begin
      applyStimulus();
      c++;
    end
    if (imem_req_valid !== 1'b1) checkOutput("req_timeout", 32'(imem_req_valid), 32'd1);
  endtask

  task automatic waitRsp(input int budget);
    int c;
    c = 0;
    while (imem_rsp_valid !== 1'b1 && c < budget) begin
      applyStimulus();
      c++;
    end
    if (imem_rsp_valid !== 1'b1) checkOutput("rsp_timeout", 32'(imem_rsp_valid), 32'd1);
  endtask

  task automatic doRedirect(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] alu, input logic [31:0] tgt);
    redir_valid    = 1'b1;
    redir_op       = op;
    redir_pc       = pc;
    redir_imm      = imm;
    redir_aluout   = alu;
    redirExpTarget = tgt;
    applyStimulus();
    redir_valid    = 1'b0;
  endtask

  // Directed sequence of scenarios.
  initial begin
    rstn = 1'b0; redir_valid = 1'b0; redir_op = 3'd0; redir_pc = '0; redir_imm = '0;
    redir_aluout = '0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if_ready = 1'b1; memLatency = 1; memActive = 1'b0; memWait = 0; memAddr = '0;
    bootFlag = 1'b1; expPc = RESET_PC; redirExpTarget = '0; heldPc = '0; heldInstr = '0;
    @(negedge clk);

    // Reset held for two cycles, then BOOT, with a redirect that BOOT must ignore.
    applyStimulus();
    applyStimulus();
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_instr", if_instr, 32'd0);
    rstn = 1'b1;
    #1;
    checkOutput("boot_req_valid", 32'(imem_req_valid), 32'd0);
    doRedirect(3'd2, 32'h100, 32'h40, 32'h0, 32'h140);
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0);

    // Streaming with 1-cycle memory: 0x0, 0x4, 0x8.
    waitLoads(3, 20);
    checkOutput("stream_last_pc", heldPc, 32'h8);

    // Backpressure: decode stalls for five cycles.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("stall_if_pc", if_pc, 32'h8);
      checkOutput("stall_if_instr", if_instr, memData(32'h8));
      applyStimulus();
    end
    if_ready = 1'b1;
    waitLoads(1, 20);
    checkOutput("resume_pc", heldPc, 32'hC);

    // Branch while waiting on a slow (2-cycle) response.
    memLatency = 2;
    waitReq(20);
    applyStimulus();
    doRedirect(3'd1, 32'h10, 32'hFFFF_FFF8, 32'h0, 32'h8);
    applyStimulus();
    waitReq(20);
    checkOutput("branch_req_addr", imem_req_addr, 32'h8);
    waitLoads(1, 20);

    // JALR in FETCH with no handshake: address switches while valid stays high.
    memLatency = 1;
    imem_req_ready = 1'b0;
    waitReq(20);
    doRedirect(3'd3, 32'h40, 32'h0, 32'h0000_0103, 32'h102);
    checkOutput("jalr_req_addr", imem_req_addr, 32'h102);
    doRedirect(3'd5, 32'h300, 32'h1234, 32'h777, 32'h304);
    checkOutput("op5_req_addr", imem_req_addr, 32'h304);
    imem_req_ready = 1'b1;
    waitLoads(1, 20);

    // Two redirects while killed; the newest target (wrapped PLUS4) wins.
    memLatency = 3;
    waitReq(20);
    applyStimulus();
    doRedirect(3'd2, 32'h200, 32'h20, 32'h0, 32'h220);
    doRedirect(3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    applyStimulus();
    waitReq(20);
    checkOutput("wrap_req_addr", imem_req_addr, 32'h0);
    waitLoads(1, 20);

    // Redirect coincident with the request handshake.
    memLatency = 1;
    waitReq(20);
    doRedirect(3'd1, 32'h80, 32'h10, 32'h0, 32'h90);
    applyStimulus();
    waitLoads(1, 20);
    checkOutput("hs_redir_pc", heldPc, 32'h90);

    // Redirect coincident with the response.
    waitRsp(20);
    doRedirect(3'd2, 32'h1000, 32'h100, 32'h0, 32'h1100);
    waitLoads(1, 20);
    checkOutput("rsp_redir_pc", heldPc, 32'h1100);

    // Reset while a fetch is outstanding; fetch restarts at RESET_PC.
    waitReq(20);
    applyStimulus();
    rstn = 1'b0;
    applyStimulus();
    checkOutput("midrst_if_valid", 32'(if_valid), 32'd0);
    rstn = 1'b1;
    applyStimulus();
    waitLoads(1, 20);
    checkOutput("midrst_pc", heldPc, RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
